// File: rtl/exec_pkg.sv
// Shared constants for the execute/writeback stage: opcodes, FSM state encoding
// and the iterative multiplier length.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam int MUL_CYCLES = 32;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/exec_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, MUL_CYCLES
// cycles after start; done marks the final iteration, when product is complete.
module exec_seq_mul
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [5:0]       cnt_q;
  logic             running_q;

  // product already includes the current iteration, so the last one needs no extra cycle
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = running_q && (cnt_q == LAST_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      mcand_q   <= a;
      mplier_q  <= b;
      acc_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 6'd1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_writeback_unit.sv
// Execute stage feeding the register_file write port with a START/BUSY/DONE handshake.
// Define EXEC_MUL_EN to build the iterative multiplier; otherwise MUL is illegal.
module exec_writeback_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic             ld,
  output logic [AW-1:0]    dr,
  output logic [WIDTH-1:0] d_in,
  output logic             zero,
  output logic             illegal
);

  logic [1:0]       state_q;
  logic [3:0]       op_q;
  logic [AW-1:0]    dest_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       cnt_q;

  logic             exec_done;
  logic             exec_illegal;
  logic [WIDTH-1:0] exec_result;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign busy = (state_q != ST_IDLE);

`ifdef EXEC_MUL_EN
  exec_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   ((state_q == ST_IDLE) && start && (op == OP_MUL)),
    .a       (data_a),
    .b       (data_b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_done    = 1'b1;
  assign mul_product = '0;
`endif

  // Shifts move a_q one bit per cycle; a zero shift amount still spends one cycle
  always_comb begin
    exec_done    = 1'b1;
    exec_illegal = 1'b0;
    exec_result  = '0;
    case (op_q)
      OP_ADD:  exec_result = a_q + b_q;
      OP_SUB:  exec_result = a_q - b_q;
      OP_AND:  exec_result = a_q & b_q;
      OP_OR:   exec_result = a_q | b_q;
      OP_XOR:  exec_result = a_q ^ b_q;
      OP_SLT:  exec_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: exec_result = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_SLL, OP_SRL, OP_SRA: begin
        if (cnt_q == 5'd0) begin
          exec_result = a_q;
        end else begin
          exec_done = (cnt_q == 5'd1);
          if (op_q == OP_SLL)      exec_result = {a_q[WIDTH-2:0], 1'b0};
          else if (op_q == OP_SRL) exec_result = {1'b0, a_q[WIDTH-1:1]};
          else                     exec_result = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        end
      end
      OP_MUL: begin
`ifdef EXEC_MUL_EN
        exec_done   = mul_done;
        exec_result = mul_product;
`else
        exec_illegal = mul_done;
        exec_result  = mul_product;
`endif
      end
      default: exec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dest_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ld      <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      zero    <= 1'b0;
      dr      <= '0;
      d_in    <= '0;
    end else begin
      ld      <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            dest_q  <= dest;
            a_q     <= data_a;
            b_q     <= data_b;
            cnt_q   <= data_b[4:0];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_shift(op_q) && (cnt_q != 5'd0)) begin
            a_q   <= exec_result;
            cnt_q <= cnt_q - 5'd1;
          end
          // Write-port outputs are registered here so they appear exactly in the WB cycle
          if (exec_done) begin
            state_q <= ST_WB;
            ld      <= 1'b1;
            done    <= 1'b1;
            illegal <= exec_illegal;
            dr      <= dest_q;
            d_in    <= exec_result;
            zero    <= (exec_result == '0);
          end
        end
        ST_WB:   state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exec_writeback_unit.md
Name: exec_writeback_unit

Overview:
- Execute stage directly downstream of register_file.
- Consumes DATA_A/DATA_B operands, performs single-cycle or iterative multi-cycle ALU operations, then drives the register_file write port (D_IN, DR, LD) for exactly one cycle.
- Provides a START/BUSY/DONE handshake to the control sequencer.

Parameters:
- WIDTH, 32, datapath width; matches the register_file word size.
- AW, 3, register address width (8 registers).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- OP  input  4  opcode; captured with START.
- DEST  input  AW  destination register; captured with START.
- DATA_A  input  WIDTH  operand A from register_file.
- DATA_B  input  WIDTH  operand B from register_file.
- BUSY  output  1  high whenever state != IDLE.
- DONE  output  1  one-cycle pulse, coincident with LD.
- LD  output  1  register_file write enable.
- DR  output  AW  register_file write address.
- D_IN  output  WIDTH  register_file write data.
- ZERO  output  1  result==0; valid while DONE.
- ILLEGAL  output  1  one-cycle pulse with DONE for an unsupported opcode.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; BUSY, DONE, LD, ZERO, ILLEGAL, DR, D_IN and all internal operand/result registers = 0. Takes effect immediately, including mid-operation; no write occurs for an aborted operation.
- FSM states: IDLE, EXEC, WB.
- IDLE: if START=1 at a rising edge, capture OP, DEST, DATA_A, DATA_B, go to EXEC. Otherwise stay.
- EXEC: occupies k cycles.
  - k=1 for ADD(0), SUB(1), AND(2), OR(3), XOR(4), SLT(5, signed), SLTU(6).
  - k=max(1, B[4:0]) for SLL(7), SRL(8), SRA(9); shift performed 1 bit per cycle. SRA replicates the sign bit.
  - k=32 for MUL(10): shift-add, low WIDTH bits of the product kept.
  - Opcodes 11–15 are illegal: k=1, result=0.
  - After the k-th EXEC cycle, go to WB.
- WB (one cycle): LD=1, DONE=1, DR=captured DEST, D_IN=result, ZERO=(result==0), ILLEGAL as applicable. Next state IDLE.
- LD, DONE and ILLEGAL are 0 in all other cycles. D_IN and DR hold their last values.
- Timing: START sampled at edge N gives EXEC in cycles N+1..N+k and WB/LD in cycle N+1+k. Earliest next START is sampled in the cycle after WB.
- START while BUSY=1 is ignored; no queueing.
- Operands are captured only at START. Later changes on DATA_A/DATA_B do not affect the in-flight operation.
- Arithmetic is modulo 2^WIDTH; no overflow flag. SLT/SLTU write 1 or 0.
- DEST=0 is a normal register and is written like any other.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: MUL(10) implemented as specified (32-cycle iterative multiply).
- Undefined: MUL treated as illegal (k=1, D_IN=0, ILLEGAL=1), and the multiplier sub-module is not instantiated.

Decomposition:
- Shared package exec_pkg: opcode constants OP_ADD..OP_MUL, state encoding constants (IDLE/EXEC/WB), MUL_CYCLES=32.
- One sub-module: exec_seq_mul, an iterative shift-add multiplier with start/done, instantiated under EXEC_MUL_EN.

Test Plan:
- Reset, then ADD: A=123, B=5, DEST=3, START at edge N → LD=1, DONE=1, DR=3, D_IN=128 in cycle N+2 only; BUSY high for N+1..N+2.
- SUB: A=5, B=7 → D_IN=0xFFFFFFFE, ZERO=0. SUB with A=B=9 → D_IN=0, ZERO=1.
- SLL: A=1, B=4 → LD in cycle N+5, D_IN=16. SRA: A=0x80000000, B=31 → D_IN=0xFFFFFFFF. Shift with B=0 → D_IN=A at N+2.
- MUL with EXEC_MUL_EN: A=6, B=7 → D_IN=42 at N+33. Without the macro → D_IN=0, ILLEGAL=1 at N+2.
- Second START pulsed during MUL BUSY → ignored; exactly one LD pulse is observed.
- RST_N dropped during MUL EXEC → BUSY=0 and LD=0 immediately; no LD pulse ever occurs for the aborted MUL. The next ADD completes normally.
